// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI bus controller.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DUMMY = 3'd3,
    DATA  = 3'd4,
    GAP   = 3'd5
  } qspi_state_e;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [3:0] NIB_ADDR   = 4'd6;
  localparam logic [3:0] NIB_DATA   = 4'd8;

  // The bus carries bytes little-endian, each high nibble first, so a byte swap
  // turns a word into its MSB-first nibble stream and back again.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_bus_ctrl_arb.sv
// Two-way arbiter for the QSPI bus: req[0] = instruction port, req[1] = data port.
// Build option QSPI_ARB_RR_EN: round-robin; otherwise fixed priority with the data port first.
module qspi_arb
  import qspi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef QSPI_ARB_RR_EN
  logic last_db_r;

  // Remember which port won the most recent grant; reset favours the data port next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_db_r <= 1'b0;
    end else if (grant != 2'b00) begin
      last_db_r <= grant[1];
    end else begin
      last_db_r <= last_db_r;
    end
  end

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_db_r ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
`else
  logic unused_s;
  assign unused_s = clk ^ rst_n;

  // Fixed priority: the data port always wins a tie.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/qspi_bus_ctrl.sv
// QSPI PMOD bus controller: ROM and PSRAM share SCK/SDIO, fetch and data ports are arbitrated.
// Build option QSPI_ARB_RR_EN selects round-robin arbitration in qspi_arb. CS_IDLE range is 1..16.
module qspi_bus_ctrl
  import qspi_pkg::*;
#(
  parameter int DUMMY_ROM = 4,
  parameter int DUMMY_RAM = 6,
  parameter int CS_IDLE   = 2
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        ib_req_i,
  input  logic [23:0] ib_addr_i,
  output logic [31:0] ib_rdata_o,
  output logic        ib_ack_o,
  input  logic        db_req_i,
  input  logic        db_we_i,
  input  logic [24:0] db_addr_i,
  input  logic [31:0] db_wdata_i,
  output logic [31:0] db_rdata_o,
  output logic        db_ack_o,
  output logic        qspi_cs_rom_on,
  output logic        qspi_cs_ram_on,
  output logic        qspi_sck_o,
  output logic [3:0]  qspi_sdo_o,
  output logic [3:0]  qspi_sdoen_o,
  input  logic [3:0]  qspi_sdi_i
);

  localparam logic [3:0] D_ROM    = 4'(DUMMY_ROM);
  localparam logic [3:0] D_RAM    = 4'(DUMMY_RAM);
  localparam logic [3:0] GAP_LAST = 4'(CS_IDLE - 1);

  qspi_state_e state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        phase_r, phase_s;
  logic [31:0] shift_r, shift_s;
  logic [31:0] wdata_r, wdata_s;
  logic [3:0]  sdo_r, sdo_s;
  logic [3:0]  dummy_r, dummy_s;
  logic        we_r, we_s;
  logic        ram_r, ram_s;
  logic        db_r, db_s;
  logic        ib_ack_r, ib_ack_s;
  logic        db_ack_r, db_ack_s;
  logic [31:0] ib_rdata_r, ib_rdata_s;
  logic [31:0] db_rdata_r, db_rdata_s;
  logic        cs_rom_r, cs_ram_r, sck_r;
  logic [3:0]  sdoen_r;
  logic [1:0]  arb_req_s, grant_s;
  logic [23:0] txn_addr_s;
  logic [7:0]  txn_cmd_s;
  logic        active_s, drive_s;

  assign arb_req_s  = (state_r == IDLE) ? {db_req_i, ib_req_i} : 2'b00;
  assign txn_addr_s = grant_s[1] ? db_addr_i[23:0] : ib_addr_i;
  assign txn_cmd_s  = (grant_s[1] && db_we_i) ? CMD_QWRITE : CMD_QREAD;

  qspi_arb u_arb (
    .clk   (clk_i),
    .rst_n (rst_in),
    .req   (arb_req_s),
    .grant (grant_s)
  );

  // Transaction sequencer: one nibble per two clk_i cycles, state advances at the end of phase 1.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    phase_s    = 1'b0;
    shift_s    = shift_r;
    wdata_s    = wdata_r;
    sdo_s      = sdo_r;
    dummy_s    = dummy_r;
    we_s       = we_r;
    ram_s      = ram_r;
    db_s       = db_r;
    ib_ack_s   = 1'b0;
    db_ack_s   = 1'b0;
    ib_rdata_s = ib_rdata_r;
    db_rdata_s = db_rdata_r;
    case (state_r)
      IDLE: begin
        if (grant_s[1] && db_we_i && !db_addr_i[24]) begin
          // ROM writes are dropped without touching the bus.
          db_s     = 1'b1;
          we_s     = 1'b1;
          ram_s    = 1'b0;
          db_ack_s = 1'b1;
          state_s  = GAP;
          cnt_s    = 4'd0;
        end else if (grant_s != 2'b00) begin
          db_s    = grant_s[1];
          we_s    = grant_s[1] & db_we_i;
          ram_s   = grant_s[1] & db_addr_i[24];
          wdata_s = byte_swap(db_wdata_i);
          dummy_s = (grant_s[1] && db_addr_i[24]) ? D_RAM : D_ROM;
          sdo_s   = txn_cmd_s[7:4];
          shift_s = {txn_cmd_s[3:0], txn_addr_s, 4'h0};
          state_s = CMD;
          cnt_s   = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        if (!phase_r) begin
          phase_s = 1'b1;
        end else begin
          cnt_s = cnt_r + 4'd1;
          case (state_r)
            CMD: begin
              sdo_s   = shift_r[31:28];
              shift_s = {shift_r[27:0], 4'h0};
              if (cnt_r == 4'd1) begin
                state_s = ADDR;
                cnt_s   = 4'd0;
              end else begin
              end
            end
            ADDR: begin
              if (cnt_r != NIB_ADDR - 4'd1) begin
                sdo_s   = shift_r[31:28];
                shift_s = {shift_r[27:0], 4'h0};
              end else begin
                cnt_s = 4'd0;
                if (we_r) begin
                  state_s = DATA;
                  sdo_s   = wdata_r[31:28];
                  shift_s = {wdata_r[27:0], 4'h0};
                end else if (dummy_r == 4'd0) begin
                  state_s = DATA;
                  sdo_s   = 4'h0;
                end else begin
                  state_s = DUMMY;
                  sdo_s   = 4'h0;
                end
              end
            end
            DUMMY: begin
              if (cnt_r == dummy_r - 4'd1) begin
                state_s = DATA;
                cnt_s   = 4'd0;
              end else begin
              end
            end
            DATA: begin
              if (we_r) begin
                sdo_s   = shift_r[31:28];
                shift_s = {shift_r[27:0], 4'h0};
              end else begin
                shift_s = {shift_r[27:0], qspi_sdi_i};
              end
              if (cnt_r == NIB_DATA - 4'd1) begin
                state_s = GAP;
                cnt_s   = 4'd0;
                sdo_s   = 4'h0;
                if (db_r) begin
                  db_ack_s = 1'b1;
                end else begin
                  ib_ack_s = 1'b1;
                end
                if (we_r) begin
                end else if (db_r) begin
                  db_rdata_s = byte_swap({shift_r[27:0], qspi_sdi_i});
                end else begin
                  ib_rdata_s = byte_swap({shift_r[27:0], qspi_sdi_i});
                end
              end else begin
              end
            end
            default: state_s = IDLE;
          endcase
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign active_s = (state_s == CMD) || (state_s == ADDR) || (state_s == DUMMY) || (state_s == DATA);
  assign drive_s  = (state_s == CMD) || (state_s == ADDR) || ((state_s == DATA) && we_s);

  // State and pad registers; pad values are derived from the next state so they leave as flops.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      phase_r    <= 1'b0;
      shift_r    <= 32'h0;
      wdata_r    <= 32'h0;
      sdo_r      <= 4'h0;
      dummy_r    <= 4'd0;
      we_r       <= 1'b0;
      ram_r      <= 1'b0;
      db_r       <= 1'b0;
      ib_ack_r   <= 1'b0;
      db_ack_r   <= 1'b0;
      ib_rdata_r <= 32'h0;
      db_rdata_r <= 32'h0;
      cs_rom_r   <= 1'b1;
      cs_ram_r   <= 1'b1;
      sck_r      <= 1'b0;
      sdoen_r    <= 4'h0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      phase_r    <= phase_s;
      shift_r    <= shift_s;
      wdata_r    <= wdata_s;
      sdo_r      <= sdo_s;
      dummy_r    <= dummy_s;
      we_r       <= we_s;
      ram_r      <= ram_s;
      db_r       <= db_s;
      ib_ack_r   <= ib_ack_s;
      db_ack_r   <= db_ack_s;
      ib_rdata_r <= ib_rdata_s;
      db_rdata_r <= db_rdata_s;
      cs_rom_r   <= !(active_s && !ram_s);
      cs_ram_r   <= !(active_s && ram_s);
      sck_r      <= active_s && phase_s;
      sdoen_r    <= {4{drive_s}};
    end
  end

  assign ib_rdata_o     = ib_rdata_r;
  assign ib_ack_o       = ib_ack_r;
  assign db_rdata_o     = db_rdata_r;
  assign db_ack_o       = db_ack_r;
  assign qspi_cs_rom_on = cs_rom_r;
  assign qspi_cs_ram_on = cs_ram_r;
  assign qspi_sck_o     = sck_r;
  assign qspi_sdo_o     = sdo_r;
  assign qspi_sdoen_o   = sdoen_r;

endmodule

// File: tb/tb_qspi_bus_ctrl.sv
// Self-checking bench for qspi_bus_ctrl with flash/PSRAM read models and an ack scoreboard.
module tb_qspi_bus_ctrl;

  localparam int DUMMY_ROM = 4;
  localparam int DUMMY_RAM = 6;
  localparam int CS_IDLE   = 2;
  localparam logic [31:0] ROM_WORD = 32'h44332211;
  localparam logic [31:0] RAM_WORD = 32'hD4C3B2A1;

  logic        clk_i = 1'b0;
  logic        rst_in = 1'b0;
  logic        ib_req_i = 1'b0;
  logic [23:0] ib_addr_i = 24'h0;
  logic [31:0] ib_rdata_o;
  logic        ib_ack_o;
  logic        db_req_i = 1'b0;
  logic        db_we_i = 1'b0;
  logic [24:0] db_addr_i = 25'h0;
  logic [31:0] db_wdata_i = 32'h0;
  logic [31:0] db_rdata_o;
  logic        db_ack_o;
  logic        qspi_cs_rom_on, qspi_cs_ram_on, qspi_sck_o;
  logic [3:0]  qspi_sdo_o, qspi_sdoen_o;
  logic [3:0]  qspi_sdi_i = 4'h0;

  qspi_bus_ctrl #(.DUMMY_ROM(DUMMY_ROM), .DUMMY_RAM(DUMMY_RAM), .CS_IDLE(CS_IDLE)) dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .ib_req_i(ib_req_i), .ib_addr_i(ib_addr_i), .ib_rdata_o(ib_rdata_o), .ib_ack_o(ib_ack_o),
    .db_req_i(db_req_i), .db_we_i(db_we_i), .db_addr_i(db_addr_i), .db_wdata_i(db_wdata_i),
    .db_rdata_o(db_rdata_o), .db_ack_o(db_ack_o),
    .qspi_cs_rom_on(qspi_cs_rom_on), .qspi_cs_ram_on(qspi_cs_ram_on), .qspi_sck_o(qspi_sck_o),
    .qspi_sdo_o(qspi_sdo_o), .qspi_sdoen_o(qspi_sdoen_o), .qspi_sdi_i(qspi_sdi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_db;
    logic        we;
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        is_db;
    logic        chk_rd;
    logic [31:0] rdata;
    int          t_exp;
  } sb_t;

  vec_t        vecs[7];
  sb_t         sb_q[$];
  logic [9:0]  cap_q[$];
  logic [9:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          nib_cnt = 0;
  int          hi_run = 0;
  int          min_gap = 1000;
  int          idle_viol = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Flash/PSRAM model: captures each nibble in its sck-high cycle and returns read data.
  always @(negedge clk_i) begin
    int d;
    int di;
    logic [31:0] w;
    logic [7:0] b;
    if (qspi_cs_rom_on && qspi_cs_ram_on) begin
      nib_cnt = 0;
      hi_run++;
      if (qspi_sck_o || qspi_sdoen_o != 4'h0) idle_viol++;
    end else begin
      if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
      if (!qspi_cs_rom_on && !qspi_cs_ram_on) idle_viol++;
      if (qspi_sck_o) begin
        cap_q.push_back({qspi_cs_rom_on, qspi_cs_ram_on, qspi_sdoen_o, qspi_sdo_o});
        d  = qspi_cs_ram_on ? DUMMY_ROM : DUMMY_RAM;
        di = nib_cnt - 8 - d;
        w  = qspi_cs_ram_on ? ROM_WORD : RAM_WORD;
        if (di >= 0 && di < 8) begin
          b = w[8*(di/2) +: 8];
          qspi_sdi_i = di[0] ? b[3:0] : b[7:4];
        end else begin
          qspi_sdi_i = 4'h0;
        end
        nib_cnt++;
      end
    end
  end

  // Scoreboard: every ack pops the oldest expectation.
  always @(negedge clk_i) begin
    sb_t e;
    if (rst_in && (ib_ack_o || db_ack_o)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got ib=%0b db=%0b expected none (cycle %0d)", ib_ack_o, db_ack_o, cyc);
      end else begin
        e = sb_q.pop_front();
        check("ack_port_db", 64'({db_ack_o, ib_ack_o}), 64'({e.is_db, !e.is_db}));
        if (e.t_exp >= 0) check("ack_cycle", 64'(cyc), 64'(e.t_exp));
        if (e.chk_rd) check("rdata", 64'(e.is_db ? db_rdata_o : ib_rdata_o), 64'(e.rdata));
      end
    end
  end

  task automatic build_exp(input vec_t v);
    logic [1:0] cs;
    logic [7:0] cmd;
    logic [23:0] a;
    int d;
    logic ram;
    exp_q.delete();
    if (v.is_db && v.we && !v.addr[24]) return;
    ram = v.is_db && v.addr[24];
    cs  = ram ? 2'b10 : 2'b01;
    cmd = (v.is_db && v.we) ? 8'h38 : 8'hEB;
    a   = v.addr[23:0];
    d   = ram ? DUMMY_RAM : DUMMY_ROM;
    exp_q.push_back({cs, 4'hF, cmd[7:4]});
    exp_q.push_back({cs, 4'hF, cmd[3:0]});
    for (int i = 5; i >= 0; i--) exp_q.push_back({cs, 4'hF, a[4*i +: 4]});
    if (!(v.is_db && v.we)) begin
      for (int i = 0; i < d; i++) exp_q.push_back({cs, 4'h0, 4'h0});
    end
    for (int i = 0; i < 4; i++) begin
      if (v.is_db && v.we) begin
        exp_q.push_back({cs, 4'hF, v.wdata[8*i+4 +: 4]});
        exp_q.push_back({cs, 4'hF, v.wdata[8*i +: 4]});
      end else begin
        exp_q.push_back({cs, 4'h0, 4'h0});
        exp_q.push_back({cs, 4'h0, 4'h0});
      end
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic got;
    logic [9:0] g;
    v = vecs[idx];
    repeat (4) @(negedge clk_i);
    cap_q.delete();
    build_exp(v);
    if (v.is_db) begin
      db_we_i = v.we; db_addr_i = v.addr; db_wdata_i = v.wdata; db_req_i = 1'b1;
    end else begin
      ib_addr_i = v.addr[23:0]; ib_req_i = 1'b1;
    end
    sb_q.push_back('{is_db: v.is_db, chk_rd: !v.we, rdata: v.exp_rdata, t_exp: cyc + v.exp_lat});
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (ib_ack_o || db_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("v%0d_ack_seen", idx), 64'(got), 64'(1));
    ib_req_i = 1'b0;
    db_req_i = 1'b0;
    check($sformatf("v%0d_nib_count", idx), 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      g = cap_q[i];
      if (exp_q[i][7:4] == 4'h0) g[3:0] = 4'h0;
      check($sformatf("v%0d_nib%0d", idx, i), 64'(g), 64'(exp_q[i]));
    end
    check($sformatf("v%0d_idle_bus", idx), 64'(idle_viol), 64'(0));
  endtask

  initial begin
    logic got;
    vecs[0] = '{1'b0, 1'b0, 25'h0000100, 32'h0,        ROM_WORD, 41};
    vecs[1] = '{1'b1, 1'b1, 25'h1000020, 32'hDEADBEEF, 32'h0,    33};
    vecs[2] = '{1'b1, 1'b0, 25'h1000000, 32'h0,        RAM_WORD, 45};
    vecs[3] = '{1'b1, 1'b0, 25'h0000ABC, 32'h0,        ROM_WORD, 41};
    vecs[4] = '{1'b1, 1'b1, 25'h0000040, 32'h12345678, 32'h0,    1};
    vecs[5] = '{1'b1, 1'b1, 25'h1FFFFFC, 32'h0F1E2D3C, 32'h0,    33};
    vecs[6] = '{1'b0, 1'b0, 25'h0FFFFFC, 32'h0,        ROM_WORD, 41};

    repeat (3) @(negedge clk_i);
    check("rst_cs_rom", 64'(qspi_cs_rom_on), 64'(1));
    check("rst_cs_ram", 64'(qspi_cs_ram_on), 64'(1));
    check("rst_sck", 64'(qspi_sck_o), 64'(0));
    check("rst_sdo", 64'(qspi_sdo_o), 64'(0));
    check("rst_sdoen", 64'(qspi_sdoen_o), 64'(0));
    check("rst_acks", 64'({ib_ack_o, db_ack_o}), 64'(0));
    check("rst_rdata", 64'({ib_rdata_o, db_rdata_o}), 64'(0));
    rst_in = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Simultaneous requests, four grants in a row.
    repeat (4) @(negedge clk_i);
    ib_addr_i = 24'h000200; db_we_i = 1'b0; db_addr_i = 25'h0000300;
    ib_req_i = 1'b1; db_req_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
`ifdef QSPI_ARB_RR_EN
      sb_q.push_back('{is_db: (n % 2) == 0, chk_rd: 1'b1, rdata: ROM_WORD, t_exp: -1});
`else
      sb_q.push_back('{is_db: 1'b1, chk_rd: 1'b1, rdata: ROM_WORD, t_exp: -1});
`endif
    end
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk_i);
        if (ib_ack_o || db_ack_o) begin
          got = 1'b1;
          break;
        end
      end
      check($sformatf("arb%0d_ack_seen", n), 64'(got), 64'(1));
      if (ib_ack_o) ib_req_i = 1'b0;
      if (db_ack_o) db_req_i = 1'b0;
      @(negedge clk_i);
      if (n < 3) begin
        ib_req_i = 1'b1; db_req_i = 1'b1;
      end else begin
        ib_req_i = 1'b0; db_req_i = 1'b0;
      end
    end

    // Reset in the middle of the address phase aborts without an ack.
    repeat (4) @(negedge clk_i);
    ib_addr_i = 24'h000100;
    ib_req_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check("pre_abort_cs_rom", 64'(qspi_cs_rom_on), 64'(0));
    check("pre_abort_sdoen", 64'(qspi_sdoen_o), 64'(4'hF));
    rst_in = 1'b0;
    #1;
    check("abort_cs", 64'({qspi_cs_rom_on, qspi_cs_ram_on}), 64'(2'b11));
    check("abort_sck", 64'(qspi_sck_o), 64'(0));
    check("abort_sdoen", 64'(qspi_sdoen_o), 64'(0));
    check("abort_ack", 64'({ib_ack_o, db_ack_o}), 64'(0));
    ib_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_in = 1'b1;
    repeat (50) @(negedge clk_i);
    run_vec(0);
    run_vec(2);

    repeat (5) @(negedge clk_i);
    check("cs_gap_min_ok", 64'(min_gap >= CS_IDLE), 64'(1));
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
